seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//  Parametrised N-digit multiplexed hex display driver; successor to the fixed 2-digit pulser path.
//  Latches a display word on a load strobe and commits it only at frame boundaries (no tearing).
//  Time-slices one digit per slot, with dead-time blanking and optional leading-zero suppression.
//  Sits between CPU-visible registers (A, PC, state) and the board's segment/digit pins.
// PARAMETERS
//  N_DIGITS        4     number of digits scanned, 1..8; digit 0 = least significant nibble
//  REFRESH_DIV     3000  clk cycles per digit slot, >= 2
//  BLANK_CYC       16    dead-time cycles at the start of each slot, 1..REFRESH_DIV-1
//  SEG_ACTIVE_LOW  1     1: segment pins are active-low
//  DIG_ACTIVE_LOW  1     1: digit-select pins are active-low
// PORTS
//  clk        in   1           system clock
//  rst_n      in   1           asynchronous active-low reset
//  value_in   in   4*N_DIGITS  hex word to display
//  dp_in      in   N_DIGITS    decimal-point mask, one bit per digit
//  load       in   1           1-cycle strobe: capture value_in/dp_in into the pending register
//  lz_blank   in   1           1: suppress leading zeros
//  enable     in   1           0: display dark and scan held at digit 0
//  seg_out    out  8           {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//  dig_out    out  N_DIGITS    one-hot digit select, polarity per DIG_ACTIVE_LOW
//  frame_done out  1           1-cycle pulse at the last cycle of digit N_DIGITS-1's slot
// BEHAVIOUR
//  Reset: slot_cnt=0, dig_idx=0, pending=0, pend_valid=0, shown=0, frame_done=0.
//   seg_out and dig_out are driven inactive (all 1s when active-low).
//  Registers:
//   - slot_cnt 0..REFRESH_DIV-1 and dig_idx 0..N_DIGITS-1.
//   - dig_idx advances when slot_cnt wraps; it wraps N_DIGITS-1 -> 0.
//  Phase FSM:
//   - OFF while enable=0.
//   - BLANK while slot_cnt < BLANK_CYC.
//   - DRIVE for the rest of the slot.
//   - OFF -> BLANK (digit 0, slot_cnt=0) on the first cycle with enable=1.
//  Outputs are registered, 1 cycle behind the counter state.
//   - In OFF/BLANK, seg_out and dig_out are both inactive.
//   - In DRIVE, dig_out[dig_idx] is active and seg_out = decode(shown nibble dig_idx) with dp = shown_dp[dig_idx].
//  Decode (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//   8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//  Leading-zero blanking: with lz_blank=1, digit i>0 is dark (dig inactive) in DRIVE when nibbles i..N-1 are all 0.
//   - Digit 0 is never blanked; dp on a blanked digit is also suppressed.
//  Load/commit:
//   - load sets pending <= value_in and pend_valid=1; a later load before commit overwrites.
//   - At the frame boundary (the frame_done cycle), if pend_valid: shown <= pending, pend_valid <= 0.
//   - load on the boundary cycle itself commits value_in directly that cycle.
//  enable falling mid-slot: outputs inactive on the next cycle; slot_cnt/dig_idx cleared; pending is kept.
//   - While enable=0 no commit happens and frame_done stays 0.
//  Asynchronous reset mid-frame returns everything to the reset values immediately.
// TESTING (bench params: N_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2, both polarities active-low)
//  1 Reset asserted -> seg_out=8'hFF, dig_out=4'hF, frame_done=0 while rst_n=0.
//  2 load 16'h12A0, enable=1, then let one frame commit.
//    -> digit-0 slot: 2 cycles dig=4'hF, then 6 cycles dig=4'b1110, seg=8'hC0.
//    -> digit 1: seg=8'h88 ("A").
//    -> frame_done pulses every 32 cycles.
//  3 shown=16'h0005, lz_blank=1 -> digits 3..1 slots keep dig=4'hF; digit 0 shows seg=8'h92.
//    With lz_blank=0, digit 3 shows seg=8'hC0.
//  4 load 16'hFFFF mid-frame -> the old value persists until the frame_done cycle; the next frame shows seg=8'h8E on all digits.
//    Load on the frame_done cycle commits immediately.
//  5 Drop enable in a DRIVE cycle of digit 2 -> next cycle seg=8'hFF, dig=4'hF.
//    Re-enable -> 2 blank cycles, then digit 0 drives.
//  6 dp_in=4'b0100 -> seg_out bit7 is 0 only during digit 2's DRIVE cycles.

Source files
------------

// File: rtl/seven_seg_scanner_if.sv
// Pin-side bundle for the multiplexed hex display scanner.
// master drives the display word and controls; slave is the scanner itself.
interface seven_seg_scanner_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] value_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic                  load;
    logic                  lz_blank;
    logic                  enable;
    logic [7:0]            seg_out;
    logic [N_DIGITS-1:0]   dig_out;
    logic                  frame_done;

    modport master (
        output value_in, dp_in, load, lz_blank, enable,
        input  seg_out, dig_out, frame_done
    );

    modport slave (
        input  value_in, dp_in, load, lz_blank, enable,
        output seg_out, dig_out, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// N-digit multiplexed hex display driver with tear-free frame-boundary commit.
// Latency: seg/dig registered one cycle behind the scan counters; frame_done marks the commit cycle.
// Backpressure: none; load is a fire-and-forget strobe, the last load before a frame boundary wins.
module seven_seg_scanner #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 3000,
    parameter int BLANK_CYC      = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    seven_seg_scanner_if.slave bus
);
    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int DIG_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]   BLANK_END = SLOT_W'(BLANK_CYC);
    localparam logic [DIG_W-1:0]    DIG_LAST  = DIG_W'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF   = {8{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] DIG_OFF   = {N_DIGITS{DIG_ACTIVE_LOW}};

    typedef enum logic [1:0] {PH_OFF, PH_BLANK, PH_DRIVE} phase_t;

    logic [SLOT_W-1:0]     slot_cnt, slot_nxt;
    logic [DIG_W-1:0]      dig_idx, dig_nxt;
    logic [4*N_DIGITS-1:0] pending, shown;
    logic [N_DIGITS-1:0]   pending_dp, shown_dp;
    logic                  pend_valid;
    logic [7:0]            seg_q, seg_nxt;
    logic [N_DIGITS-1:0]   dig_q, dig_sel_nxt, dig_hot;
    logic                  frame_done_q, fd_nxt;
    logic [3:0]            nib;
    logic                  cur_dp, cur_dark, zero_above;
    phase_t                phase;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt     <= '0;
            dig_idx      <= '0;
            seg_q        <= SEG_OFF;
            dig_q        <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            slot_cnt     <= slot_nxt;
            dig_idx      <= dig_nxt;
            seg_q        <= seg_nxt;
            dig_q        <= dig_sel_nxt;
            frame_done_q <= fd_nxt;
        end
    end

    always_comb begin
        phase       = PH_OFF;
        slot_nxt    = '0;
        dig_nxt     = '0;
        seg_nxt     = SEG_OFF;
        dig_sel_nxt = DIG_OFF;
        nib         = 4'h0;
        cur_dp      = 1'b0;
        cur_dark    = 1'b0;
        dig_hot     = '0;
        zero_above  = 1'b1;

        if (bus.enable) begin
            phase = (slot_cnt < BLANK_END) ? PH_BLANK : PH_DRIVE;
            if (slot_cnt == SLOT_LAST) begin
                dig_nxt = (dig_idx == DIG_LAST) ? '0 : dig_idx + DIG_W'(1);
            end else begin
                slot_nxt = slot_cnt + SLOT_W'(1);
                dig_nxt  = dig_idx;
            end
        end

        // Walk from the most significant digit so zero_above covers nibbles i..N-1.
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (shown[4*i +: 4] == 4'h0);
            if (dig_idx == DIG_W'(i)) begin
                nib        = shown[4*i +: 4];
                cur_dp     = shown_dp[i];
                cur_dark   = bus.lz_blank && (i != 0) && zero_above;
                dig_hot[i] = 1'b1;
            end
        end

        if (phase == PH_DRIVE && !cur_dark) begin
            seg_nxt     = {cur_dp, seg_decode(nib)} ^ SEG_OFF;
            dig_sel_nxt = dig_hot ^ DIG_OFF;
        end

        fd_nxt = bus.enable && (slot_nxt == SLOT_LAST) && (dig_nxt == DIG_LAST);
    end

    // frame_done_q is high exactly while the counters sit on the frame's last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            pending_dp <= '0;
            pend_valid <= 1'b0;
            shown      <= '0;
            shown_dp   <= '0;
        end else if (frame_done_q && bus.enable) begin
            if (bus.load) begin
                shown      <= bus.value_in;
                shown_dp   <= bus.dp_in;
                pending    <= bus.value_in;
                pending_dp <= bus.dp_in;
            end else if (pend_valid) begin
                shown    <= pending;
                shown_dp <= pending_dp;
            end
            pend_valid <= 1'b0;
        end else if (bus.load) begin
            pending    <= bus.value_in;
            pending_dp <= bus.dp_in;
            pend_valid <= 1'b1;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dig_out    = dig_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: flat-counter reference model checked every cycle plus literal pins.
module tb_seven_seg_scanner;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seven_seg_scanner_if #(.N_DIGITS(4)) bus ();

    seven_seg_scanner #(
        .N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Reference model: en_cnt counts enabled cycles since the scan (re)started.
    int         en_cnt, slot, digit, nibv, t0;
    logic [15:0] shown_m, pend_m, upper;
    logic [3:0]  sdp_m, pdp_m;
    bit          pv_m;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cnt = 0; shown_m = '0; pend_m = '0; sdp_m = '0; pdp_m = '0; pv_m = 0;
            exp_seg = 8'hFF; exp_dig = 4'hF; exp_fd = 1'b0;
        end else begin
            slot  = en_cnt % 8;
            digit = (en_cnt / 8) % 4;
            exp_seg = 8'hFF;
            exp_dig = 4'hF;
            if (bus.enable && slot >= 2) begin
                upper = shown_m >> (4 * digit);
                if (!(bus.lz_blank && digit > 0 && upper == 16'h0)) begin
                    nibv    = int'(upper & 16'hF);
                    exp_seg = ~{sdp_m[digit], SEG_TAB[nibv]};
                    exp_dig = ~(4'b0001 << digit);
                end
            end
            if (bus.enable && (en_cnt % 32 == 31)) begin
                if (bus.load) begin
                    shown_m = bus.value_in; sdp_m = bus.dp_in;
                end else if (pv_m) begin
                    shown_m = pend_m; sdp_m = pdp_m;
                end
                pv_m = 0;
            end else if (bus.load) begin
                pend_m = bus.value_in; pdp_m = bus.dp_in; pv_m = 1;
            end
            en_cnt = bus.enable ? en_cnt + 1 : 0;
            exp_fd = (en_cnt % 32 == 31);
        end
    end

    always @(negedge clk) begin
        checks++;
        if (bus.seg_out !== exp_seg || bus.dig_out !== exp_dig || bus.frame_done !== exp_fd) begin
            failures++;
            $display("FAIL model cyc=%0d: seg=%h dig=%b fd=%b, expected seg=%h dig=%b fd=%b",
                     cyc, bus.seg_out, bus.dig_out, bus.frame_done, exp_seg, exp_dig, exp_fd);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd();
        bit ok;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_fd: got timeout expected frame_done within 100 cycles");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.value_in = '0; bus.dp_in = '0; bus.load = 1'b0;
        bus.lz_blank = 1'b0; bus.enable = 1'b0;

        // Reset state
        tick(3);
        check("rst_seg", bus.seg_out, 8'hFF);
        check("rst_dig", bus.dig_out, 4'hF);
        check("rst_fd", bus.frame_done, 1'b0);
        rst_n = 1'b1;
        tick(2);
        check("off_dig", bus.dig_out, 4'hF);

        // Load 12A0 and enable; commit at the first boundary
        bus.value_in = 16'h12A0; bus.load = 1'b1; bus.enable = 1'b1;
        tick(1);
        bus.load = 1'b0;
        wait_fd();
        t0 = cyc;
        tick(3);
        check("t2_blank_dig", bus.dig_out, 4'hF);
        tick(1);
        check("t2_d0_dig", bus.dig_out, 4'b1110);
        check("t2_d0_seg", bus.seg_out, 8'hC0);
        tick(8);
        check("t2_d1_dig", bus.dig_out, 4'b1101);
        check("t2_d1_seg", bus.seg_out, 8'h88);
        wait_fd();
        check("t2_period", cyc - t0, 32);

        // Leading-zero blanking on 0005
        tick(1);
        bus.value_in = 16'h0005; bus.load = 1'b1; bus.lz_blank = 1'b1;
        tick(1);
        bus.load = 1'b0;
        wait_fd();
        tick(4);
        check("t3_d0_seg", bus.seg_out, 8'h92);
        check("t3_d0_dig", bus.dig_out, 4'b1110);
        tick(8);
        check("t3_d1_dark", bus.dig_out, 4'hF);
        tick(16);
        check("t3_d3_dark", bus.dig_out, 4'hF);
        bus.lz_blank = 1'b0;
        tick(1);
        check("t3_d3_seg", bus.seg_out, 8'hC0);
        check("t3_d3_dig", bus.dig_out, 4'b0111);

        // Mid-frame load holds off until the boundary
        bus.value_in = 16'hFFFF; bus.load = 1'b1;
        tick(1);
        bus.load = 1'b0;
        check("t4_old_seg", bus.seg_out, 8'hC0);
        wait_fd();
        tick(4);
        check("t4_new_d0", bus.seg_out, 8'h8E);
        tick(8);
        check("t4_new_d1", bus.seg_out, 8'h8E);
        check("t4_new_d1_dig", bus.dig_out, 4'b1101);
        // Load on the boundary cycle itself
        wait_fd();
        bus.value_in = 16'h0007; bus.load = 1'b1;
        tick(1);
        bus.load = 1'b0;
        tick(3);
        check("t4_direct_seg", bus.seg_out, 8'hF8);

        // Enable drop during digit 2 DRIVE; pending load while disabled
        tick(16);
        check("t5_d2_dig", bus.dig_out, 4'b1011);
        bus.enable = 1'b0;
        tick(1);
        check("t5_off_seg", bus.seg_out, 8'hFF);
        check("t5_off_dig", bus.dig_out, 4'hF);
        bus.value_in = 16'h1234; bus.dp_in = 4'b0100; bus.load = 1'b1;
        tick(1);
        bus.load = 1'b0;
        tick(40);
        check("t5_no_fd", bus.frame_done, 1'b0);
        bus.enable = 1'b1;
        tick(1);
        check("t5_re_blank0", bus.dig_out, 4'hF);
        tick(1);
        check("t5_re_blank1", bus.dig_out, 4'hF);
        tick(1);
        check("t5_re_d0_dig", bus.dig_out, 4'b1110);
        check("t5_re_d0_seg", bus.seg_out, 8'hF8);

        // Decimal point on digit 2 only
        wait_fd();
        tick(12);
        check("t6_d1_seg", bus.seg_out, 8'hB0);
        tick(8);
        check("t6_d2_seg", bus.seg_out, 8'h24);
        check("t6_d2_dig", bus.dig_out, 4'b1011);

        // Asynchronous reset mid-frame
        #2 rst_n = 1'b0;
        #1;
        check("t7_arst_seg", bus.seg_out, 8'hFF);
        check("t7_arst_dig", bus.dig_out, 4'hF);
        tick(2);
        rst_n = 1'b1;
        wait_fd();
        tick(4);
        check("t7_shown_cleared", bus.seg_out, 8'hC0);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
